wb_cmd_master: RTL and testbench

Wishbone classic initiator that converts a simple valid/ready command stream into single read/write bus cycles on the user-area Wishbone bus and returns one response per command. It is the initiating end of the same bus that the GPIO expander peripheral answers as a responder. It lets on-chip logic such as LA-driven or UART-driven test controllers exercise peripherals without the management SoC. A watchdog can terminate cycles that never acknowledge.

---
 rtl/wb_master_pkg.sv | 25 ++
 rtl/wb_master_watchdog.sv | 33 +++
 rtl/wb_cmd_master.sv | 115 +++++++++++
 tb/tb_wb_cmd_master.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_master_pkg.sv
// Shared types and constants for the Wishbone command master.
package wb_master_pkg;

  localparam int ADR_W = 32;
  localparam int DAT_W = 32;
  localparam int SEL_W = 4;
  localparam int CNT_W = 16;

  localparam int unsigned DEF_TIMEOUT = 255;
  localparam logic [DAT_W-1:0] DEF_ERR_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUS,
    ST_RESP
  } state_t;

  typedef struct packed {
    logic             we;
    logic [ADR_W-1:0] adr;
    logic [DAT_W-1:0] dat;
    logic [SEL_W-1:0] sel;
  } cmd_t;

endpackage

// File: rtl/wb_master_watchdog.sv
// Loadable up-counter with clear/enable; flags the final cycle
// before LIMIT counts have elapsed.
module wb_master_watchdog
  import wb_master_pkg::*;
#(
  parameter int unsigned LIMIT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign expired = en && (count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone classic initiator: one command in, one bus cycle, one response.
// WB_MASTER_TIMEOUT_EN enables the no-ack watchdog.
module wb_cmd_master
  import wb_master_pkg::*;
#(
  parameter int unsigned       TIMEOUT  = DEF_TIMEOUT,
  parameter logic [DAT_W-1:0]  ERR_DATA = DEF_ERR_DATA
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_we_i,
  input  logic [ADR_W-1:0] cmd_adr_i,
  input  logic [DAT_W-1:0] cmd_dat_i,
  input  logic [SEL_W-1:0] cmd_sel_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [DAT_W-1:0] rsp_dat_o,
  output logic             rsp_err_o,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [SEL_W-1:0] wbm_sel_o,
  output logic [ADR_W-1:0] wbm_adr_o,
  output logic [DAT_W-1:0] wbm_dat_o,
  input  logic [DAT_W-1:0] wbm_dat_i,
  input  logic             wbm_ack_i
);

  state_t state;
  cmd_t   bus_q;
  logic   expired;

`ifdef WB_MASTER_TIMEOUT_EN
  wb_master_watchdog #(
    .LIMIT (TIMEOUT)
  ) u_wd (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .clr      (state == ST_IDLE),
    .en       (state == ST_BUS),
    .load     (1'b0),
    .load_val ('0),
    .expired  (expired)
  );
`else
  // TIMEOUT is at least 1, so without a watchdog this never fires
  assign expired = (TIMEOUT == 0);
`endif

  assign wbm_we_o  = bus_q.we;
  assign wbm_adr_o = bus_q.adr;
  assign wbm_dat_o = bus_q.dat;
  assign wbm_sel_o = bus_q.sel;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state       <= ST_IDLE;
      bus_q       <= '0;
      cmd_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_dat_o   <= '0;
      rsp_err_o   <= 1'b0;
      wbm_cyc_o   <= 1'b0;
      wbm_stb_o   <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (cmd_valid_i) begin
            bus_q.we    <= cmd_we_i;
            bus_q.adr   <= cmd_adr_i;
            bus_q.dat   <= cmd_dat_i;
            bus_q.sel   <= cmd_sel_i;
            cmd_ready_o <= 1'b0;
            wbm_cyc_o   <= 1'b1;
            wbm_stb_o   <= 1'b1;
            state       <= ST_BUS;
          end
        end
        ST_BUS: begin
          // ack takes priority over a coincident timeout
          if (wbm_ack_i) begin
            rsp_dat_o   <= bus_q.we ? '0 : wbm_dat_i;
            rsp_err_o   <= 1'b0;
            rsp_valid_o <= 1'b1;
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            bus_q.we    <= 1'b0;
            state       <= ST_RESP;
          end else if (expired) begin
            rsp_dat_o   <= bus_q.we ? '0 : ERR_DATA;
            rsp_err_o   <= 1'b1;
            rsp_valid_o <= 1'b1;
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            bus_q.we    <= 1'b0;
            state       <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            cmd_ready_o <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Randomized bench for wb_cmd_master against a transaction-level model.
module tb_wb_cmd_master;

  localparam int TO = 8;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;
  localparam int BUS_LIMIT = 4 * TO;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [31:0] cmd_adr = '0;
  logic [31:0] cmd_dat = '0;
  logic [3:0]  cmd_sel = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        wcyc, wstb, wwe;
  logic [3:0]  wsel;
  logic [31:0] wadr, wdat_o;
  logic [31:0] wdat_i = '0;
  logic        wack = 1'b0;

  int n_chk = 0;
  int n_err = 0;
  int cyc_cnt = 0;

  wb_cmd_master #(
    .TIMEOUT  (TO),
    .ERR_DATA (ERR)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_we_i    (cmd_we),
    .cmd_adr_i   (cmd_adr),
    .cmd_dat_i   (cmd_dat),
    .cmd_sel_i   (cmd_sel),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_dat_o   (rsp_dat),
    .rsp_err_o   (rsp_err),
    .wbm_cyc_o   (wcyc),
    .wbm_stb_o   (wstb),
    .wbm_we_o    (wwe),
    .wbm_sel_o   (wsel),
    .wbm_adr_o   (wadr),
    .wbm_dat_o   (wdat_o),
    .wbm_dat_i   (wdat_i),
    .wbm_ack_i   (wack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt++;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: stb-high cycles for a responder that acks after `waits`
  // wait states (waits < 0 means never).
  function automatic int exp_cycles(input int waits);
`ifdef WB_MASTER_TIMEOUT_EN
    if (waits < 0 || waits >= TO) return TO;
    return waits + 1;
`else
    if (waits < 0) return BUS_LIMIT;
    return waits + 1;
`endif
  endfunction

  function automatic logic exp_acked(input int waits);
`ifdef WB_MASTER_TIMEOUT_EN
    return (waits >= 0) && (waits < TO);
`else
    return (waits >= 0);
`endif
  endfunction

  task automatic issue(input logic we, input logic [31:0] adr,
                       input logic [31:0] dat, input logic [3:0] sel,
                       output int acc);
    int t;
    logic rdy;
    cmd_valid = 1'b1;
    cmd_we = we;
    cmd_adr = adr;
    cmd_dat = dat;
    cmd_sel = sel;
    t = 0;
    do begin
      rdy = cmd_ready;
      step();
      t++;
    end while (!rdy && t < 10);
    cmd_valid = 1'b0;
    cmd_we = $urandom;
    cmd_adr = $urandom;
    cmd_dat = $urandom;
    chk("accept", rdy, 1'b1);
    acc = cyc_cnt;
  endtask

  task automatic run_txn(input logic we, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel,
                         input int waits, input logic [31:0] rdat,
                         input int hold, output int acc);
    int n;
    logic acked;
    logic [31:0] exp_dat;
    acked = exp_acked(waits);
    exp_dat = we ? 32'h0 : (acked ? rdat : ERR);
    issue(we, adr, dat, sel, acc);
    n = 0;
    while (wstb && n < BUS_LIMIT) begin
      chk("cyc", wcyc, 1'b1);
      chk("adr", wadr, adr);
      chk("wdat", wdat_o, dat);
      chk("we", wwe, we);
      chk("sel", wsel, sel);
      chk("rdy_bus", cmd_ready, 1'b0);
      chk("rv_bus", rsp_valid, 1'b0);
      wack = (n == waits);
      wdat_i = (n == waits) ? rdat : $urandom;
      step();
      n++;
    end
    wack = 1'b0;
    chk("stb_cycles", n, exp_cycles(waits));
    chk("cyc_off", wcyc, 1'b0);
    chk("rsp_valid", rsp_valid, 1'b1);
    chk("rsp_dat", rsp_dat, exp_dat);
    chk("rsp_err", rsp_err, !acked);
    for (int h = 0; h < hold; h++) begin
      cmd_valid = 1'b1;
      cmd_adr = $urandom;
      wack = $urandom;
      wdat_i = $urandom;
      step();
      chk("hold_valid", rsp_valid, 1'b1);
      chk("hold_dat", rsp_dat, exp_dat);
      chk("hold_err", rsp_err, !acked);
      chk("hold_rdy", cmd_ready, 1'b0);
      chk("hold_cyc", wcyc, 1'b0);
    end
    cmd_valid = 1'b0;
    wack = 1'b0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("rsp_done", rsp_valid, 1'b0);
    chk("rdy_back", cmd_ready, 1'b1);
  endtask

  initial begin
    int a1, a2, stall, n;
    logic we;
    logic [31:0] d;

    repeat (3) step();
    rst = 1'b0;
    chk("rst_ready", cmd_ready, 1'b1);
    chk("rst_rvalid", rsp_valid, 1'b0);
    chk("rst_rdat", rsp_dat, 32'h0);
    chk("rst_err", rsp_err, 1'b0);
    chk("rst_cyc", wcyc, 1'b0);
    chk("rst_stb", wstb, 1'b0);
    chk("rst_we", wwe, 1'b0);
    chk("rst_adr", wadr, 32'h0);
    chk("rst_wdat", wdat_o, 32'h0);
    chk("rst_sel", wsel, 4'h0);

    run_txn(1'b1, 32'h3000_0004, 32'h0000_00FF, 4'hF, 0, 32'h0, 0, a1);
    run_txn(1'b0, 32'h3000_0000, 32'h0, 4'hF, 3, 32'hA5A5_1234, 0, a1);
`ifdef WB_MASTER_TIMEOUT_EN
    run_txn(1'b0, 32'h3000_0010, 32'h0, 4'hF, -1, 32'h0, 1, a1);
    run_txn(1'b1, 32'h3000_0014, 32'h1111_2222, 4'h3, -1, 32'h0, 0, a1);
`endif
    run_txn(1'b0, 32'h3000_0020, 32'h0, 4'hF, TO - 1, 32'h1234_5678,
            0, a1);
    run_txn(1'b0, 32'h3000_0024, 32'h0, 4'hC, 1, 32'h0BAD_F00D, 5, a1);

    run_txn(1'b0, 32'h3000_0030, 32'h0, 4'hF, 0, 32'hCAFE_0001, 0, a1);
    run_txn(1'b1, 32'h3000_0034, 32'h5555_AAAA, 4'hF, 0, 32'h0, 0, a2);
    chk("thruput", a2 - a1, 3);

    for (int i = 0; i < 24; i++) begin
      we = $urandom;
      d = $urandom;
      run_txn(we, $urandom, d, 4'($urandom), $urandom_range(0, TO + 2),
              $urandom, $urandom_range(0, 3), a1);
    end

`ifdef WB_MASTER_TIMEOUT_EN
    stall = 3;
`else
    stall = BUS_LIMIT;
`endif
    issue(1'b0, 32'h3000_0008, 32'h0, 4'hF, a1);
    n = 0;
    while (wstb && n < stall) begin
      step();
      n++;
    end
    chk("stall_cycles", n, stall);
    chk("stall_stb", wstb, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_cyc", wcyc, 1'b0);
    chk("mid_rst_stb", wstb, 1'b0);
    chk("mid_rst_we", wwe, 1'b0);
    chk("mid_rst_adr", wadr, 32'h0);
    chk("mid_rst_sel", wsel, 4'h0);
    chk("mid_rst_ready", cmd_ready, 1'b1);
    chk("mid_rst_rvalid", rsp_valid, 1'b0);
    wack = 1'b1;
    wdat_i = 32'h7777_7777;
    step();
    wack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("late_ack_rv", rsp_valid, 1'b0);
      chk("late_ack_cyc", wcyc, 1'b0);
      chk("late_ack_rdy", cmd_ready, 1'b1);
      step();
    end

    run_txn(1'b0, 32'h3000_0040, 32'h0, 4'hF, 2, 32'h600D_CAFE, 1, a1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
